// File: rtl/glb_stream_reader.sv
// glb_stream_reader
//   Reads a burst of words from a global buffer (GLB) and streams them out
//   through a valid/ready interface. A burst is requested with a one-cycle
//   start pulse carrying a base address and a word count. Reads are issued
//   one per cycle, the address wraps modulo DEPTH, and the returned data is
//   staged in a 2-entry FIFO so that stream backpressure never drops or
//   repeats a word.
//
// Ports
//   core_clk   : single clock, all flops on the rising edge
//   reset      : asynchronous, active-high
//   start      : one-cycle burst request (ignored while busy)
//   base_addr  : first word address, sampled with start
//   length     : word count 0..DEPTH, sampled with start
//   busy       : burst in progress (RUN or DRAIN)
//   done       : one-cycle pulse after the burst completes
//   re         : GLB read enable (registered)
//   raddr      : GLB read address (registered)
//   rdata      : GLB read data, valid by the end of a cycle with re=1
//   out_data   : stream data (FIFO head)
//   out_valid  : stream valid (FIFO non-empty)
//   out_ready  : stream backpressure
module glb_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR-1:0]       base_addr,
    input  logic [ADDR:0]         length,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [ADDR-1:0]       raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [ADDR-1:0] ADDR_ONE  = ADDR'(1);
    localparam logic [ADDR:0]   LEN_ONE   = (ADDR + 1)'(1);

    state_t                  state;
    logic [ADDR:0]           reads_left;   // reads still to be issued
    logic [ADDR-1:0]         next_addr;    // address of the next read

    // 2-entry FIFO
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic [1:0]              count_next;

    logic                    push;
    logic                    pop;

    function automatic logic [ADDR-1:0] wrap_inc(input logic [ADDR-1:0] a);
        if (a == LAST_ADDR) begin
            return '0;
        end
        return a + ADDR_ONE;
    endfunction

    // A read issued this cycle lands in the FIFO at the closing edge, so
    // re itself is the push strobe.
    assign push      = re;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // A new read is launched only when the FIFO occupancy after this edge
    // is below 2: that read then occupies the single in-flight slot and is
    // guaranteed a free entry when it lands one cycle later.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            re          <= 1'b0;
            raddr       <= '0;
            reads_left  <= '0;
            next_addr   <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
        end else begin
            done  <= 1'b0;
            count <= count_next;

            if (push) begin
                fifo_mem[wr_ptr] <= rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case (state)
                IDLE: begin
                    re <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            // First read goes out in the cycle right after start.
                            state      <= RUN;
                            re         <= 1'b1;
                            raddr      <= base_addr;
                            next_addr  <= wrap_inc(base_addr);
                            reads_left <= length - LEN_ONE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (re && (reads_left == '0)) begin
                        // The final read is completing; nothing left to issue.
                        state <= DRAIN;
                        re    <= 1'b0;
                    end else if ((reads_left != '0) && (count_next < 2'd2)) begin
                        re         <= 1'b1;
                        raddr      <= next_addr;
                        next_addr  <= wrap_inc(next_addr);
                        reads_left <= reads_left - LEN_ONE;
                    end else begin
                        re <= 1'b0;
                    end
                end

                DRAIN: begin
                    re <= 1'b0;
                    // No pushes happen in DRAIN, so popping the last stored
                    // entry ends the burst.
                    if (pop && (count == 2'd1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    re    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glb_stream_reader.sv
// tb_glb_stream_reader
//   Directed bench for glb_stream_reader with DEPTH=4 and a GLB holding
//   {A,B,C,D}. The GLB model updates rdata on the falling edge of a cycle
//   with re=1. A falling-edge monitor logs reads, transfers and done pulses.
module tb_glb_stream_reader;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int ADDR  = 2;

    localparam logic [DW-1:0] WA = 16'hAAAA;
    localparam logic [DW-1:0] WB = 16'hBBBB;
    localparam logic [DW-1:0] WC = 16'hCCCC;
    localparam logic [DW-1:0] WD = 16'hDDDD;

    logic            core_clk  = 1'b0;
    logic            reset     = 1'b1;
    logic            start     = 1'b0;
    logic [ADDR-1:0] base_addr = '0;
    logic [ADDR:0]   length    = '0;
    logic            busy;
    logic            done;
    logic            re;
    logic [ADDR-1:0] raddr;
    logic [DW-1:0]   rdata     = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;

    logic [DW-1:0]   mem [DEPTH];

    int total = 0;
    int bad   = 0;

    glb_stream_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR       (ADDR)
    ) dut (
        .core_clk  (core_clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        mem[0] = WA;
        mem[1] = WB;
        mem[2] = WC;
        mem[3] = WD;
    end

    // GLB model
    always @(negedge core_clk) begin
        if (re) rdata <= mem[raddr];
    end

    // Monitor
    logic [DW-1:0]   xfer_q  [$];
    logic [ADDR-1:0] raddr_q [$];
    int cyc = 0;
    int re_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;

    always @(posedge core_clk) cyc = cyc + 1;

    always @(negedge core_clk) begin
        if (re) begin
            re_cnt = re_cnt + 1;
            raddr_q.push_back(raddr);
        end
        if (out_valid) valid_cnt = valid_cnt + 1;
        if (out_valid && out_ready) begin
            xfer_q.push_back(out_data);
            last_xfer_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    // Drives a one-cycle start; returns just after the sampling edge.
    task automatic pulse_start(input logic [ADDR-1:0] b, input logic [ADDR:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (re !== 1'b0)        begin bad++; $display("FAIL reset_re got=%b exp=0", re); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (raddr !== '0)       begin bad++; $display("FAIL reset_raddr got=%0d exp=0", raddr); end
        total++; if (out_data !== '0)    begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_basic();
        // after edges E0..E6 following start (base=1, length=4, ready=1)
        logic          e_re    [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [1:0]    e_raddr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic          e_val   [7] = '{0, 1, 1, 1, 1, 0, 0};
        logic [DW-1:0] e_data  [4] = '{WB, WC, WD, WA};
        logic          e_done  [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic          e_busy  [7] = '{1, 1, 1, 1, 1, 0, 0};
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        pulse_start(2'd1, 3'd4);
        for (int e = 0; e < 7; e++) begin
            if (e > 0) step();
            total++; if (re !== e_re[e])     begin bad++; $display("FAIL basic_re e%0d got=%b exp=%b", e, re, e_re[e]); end
            total++; if (out_valid !== e_val[e]) begin bad++; $display("FAIL basic_valid e%0d got=%b exp=%b", e, out_valid, e_val[e]); end
            total++; if (done !== e_done[e]) begin bad++; $display("FAIL basic_done e%0d got=%b exp=%b", e, done, e_done[e]); end
            total++; if (busy !== e_busy[e]) begin bad++; $display("FAIL basic_busy e%0d got=%b exp=%b", e, busy, e_busy[e]); end
            if (e < 4) begin
                total++; if (raddr !== e_raddr[e]) begin bad++; $display("FAIL basic_raddr e%0d got=%0d exp=%0d", e, raddr, e_raddr[e]); end
            end
            if (e >= 1 && e <= 4) begin
                total++; if (out_data !== e_data[e-1]) begin bad++; $display("FAIL basic_data e%0d got=%h exp=%h", e, out_data, e_data[e-1]); end
            end
        end
        step();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int r0, v0, d0;
        r0 = re_cnt; v0 = valid_cnt; d0 = done_cnt;
        out_ready = 1'b1;
        pulse_start(2'd2, 3'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_clear got=%b exp=0", done); end
        repeat (3) step();
        total++; if (re_cnt - r0 !== 0)    begin bad++; $display("FAIL zero_reads got=%0d exp=0", re_cnt - r0); end
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL zero_valid got=%0d exp=0", valid_cnt - v0); end
        total++; if (done_cnt - d0 !== 1)  begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e_data [4] = '{WA, WB, WC, WD};
        int r0, x0, d0;
        bit ok;
        r0 = re_cnt; x0 = xfer_q.size(); d0 = done_cnt;
        out_ready = 1'b0;
        pulse_start(2'd0, 3'd4);
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got=%b exp=1", i, out_valid); end
            total++; if (out_data !== WA)    begin bad++; $display("FAIL bp_hold c%0d got=%h exp=%h", i, out_data, WA); end
        end
        total++; if (re_cnt - r0 > 2) begin bad++; $display("FAIL bp_reads got=%0d exp<=2", re_cnt - r0); end
        out_ready = 1'b1;
        wait_done(30, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
        total++; if (xfer_q.size() - x0 !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", xfer_q.size() - x0); end
        for (int i = 0; i < 4 && x0 + i < xfer_q.size(); i++) begin
            total++; if (xfer_q[x0+i] !== e_data[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, xfer_q[x0+i], e_data[i]); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_random_ready();
        logic [15:0]   pat = 16'b1011_0010_0110_1101;
        logic [DW-1:0] e_data [4] = '{WC, WD, WA, WB};
        int x0, d0;
        bit ok;
        x0 = xfer_q.size(); d0 = done_cnt;
        ok = 1'b0;
        out_ready = pat[0];
        pulse_start(2'd2, 3'd4);
        for (int i = 1; i < 60; i++) begin
            out_ready = pat[i % 16];
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd_timeout got=0 exp=1"); end
        total++; if (xfer_q.size() - x0 !== 4) begin bad++; $display("FAIL rnd_count got=%0d exp=4", xfer_q.size() - x0); end
        for (int i = 0; i < 4 && x0 + i < xfer_q.size(); i++) begin
            total++; if (xfer_q[x0+i] !== e_data[i]) begin bad++; $display("FAIL rnd_word%0d got=%h exp=%h", i, xfer_q[x0+i], e_data[i]); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rnd_done_count got=%0d exp=1", done_cnt - d0); end
        total++; if (done_cyc !== last_xfer_cyc + 1) begin bad++; $display("FAIL rnd_done_lag got=%0d exp=%0d", done_cyc, last_xfer_cyc + 1); end
        out_ready = 1'b1;
    endtask

    task automatic test_start_ignored();
        logic [1:0]    e_raddr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [DW-1:0] e_data  [4] = '{WB, WC, WD, WA};
        int r0, x0, d0;
        bit ok;
        r0 = raddr_q.size(); x0 = xfer_q.size(); d0 = done_cnt;
        out_ready = 1'b1;
        pulse_start(2'd1, 3'd4);
        step();
        pulse_start(2'd3, 3'd2);
        wait_done(30, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ign_timeout got=0 exp=1"); end
        total++; if (raddr_q.size() - r0 !== 4) begin bad++; $display("FAIL ign_reads got=%0d exp=4", raddr_q.size() - r0); end
        for (int i = 0; i < 4 && r0 + i < raddr_q.size(); i++) begin
            total++; if (raddr_q[r0+i] !== e_raddr[i]) begin bad++; $display("FAIL ign_raddr%0d got=%0d exp=%0d", i, raddr_q[r0+i], e_raddr[i]); end
        end
        for (int i = 0; i < 4 && x0 + i < xfer_q.size(); i++) begin
            total++; if (xfer_q[x0+i] !== e_data[i]) begin bad++; $display("FAIL ign_word%0d got=%h exp=%h", i, xfer_q[x0+i], e_data[i]); end
        end
        total++; if (xfer_q.size() - x0 !== 4) begin bad++; $display("FAIL ign_count got=%0d exp=4", xfer_q.size() - x0); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int x0, d0;
        bit ok;
        x0 = xfer_q.size();
        out_ready = 1'b1;
        ok = 1'b0;
        pulse_start(2'd0, 3'd4);
        for (int i = 0; i < 20; i++) begin
            if (xfer_q.size() - x0 >= 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_mid_timeout got=0 exp=1"); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (re !== 1'b0)        begin bad++; $display("FAIL rst_mid_re got=%b exp=0", re); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        total++; if (raddr !== '0)       begin bad++; $display("FAIL rst_mid_raddr got=%0d exp=0", raddr); end
        total++; if (out_data !== '0)    begin bad++; $display("FAIL rst_mid_data got=%h exp=0", out_data); end
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt - d0); end
        x0 = xfer_q.size();
        pulse_start(2'd0, 3'd2);
        wait_done(20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_after_timeout got=0 exp=1"); end
        total++; if (xfer_q.size() - x0 !== 2) begin bad++; $display("FAIL rst_after_count got=%0d exp=2", xfer_q.size() - x0); end
        if (xfer_q.size() - x0 >= 2) begin
            total++; if (xfer_q[x0] !== WA)   begin bad++; $display("FAIL rst_after_word0 got=%h exp=%h", xfer_q[x0], WA); end
            total++; if (xfer_q[x0+1] !== WB) begin bad++; $display("FAIL rst_after_word1 got=%h exp=%h", xfer_q[x0+1], WB); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rst_after_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    initial begin
        #3;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
